// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA debug text writer.
// Holds the ASCII encoding anchors and the writer state enum.
package vga_pkg;

    localparam int HEX_HILITE_BIT = 7;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    typedef enum logic {
        IDLE,
        WRITE
    } wr_state_e;

endpackage

// File: rtl/vga_hex_char.sv
// Nibble to uppercase hex ASCII, with the highlight flag in bit 7.
// Purely combinational; the caller registers the result.
module vga_hex_char
    import vga_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       hl_i,
    output logic [7:0] code_o
);

    logic [7:0] nib_w;

    // Digits map onto '0'..'9', letters onto 'A'..'F'
    always_comb begin
        nib_w  = {4'h0, nib_i};
        code_o = (nib_i < 4'd10) ? ASCII_0 + nib_w
                                 : ASCII_A + nib_w - 8'd10;
        code_o[HEX_HILITE_BIT] = hl_i;
    end

endmodule

// File: rtl/vga_hex_writer.sv
// Streams hex renderings of debug channels into the VGA char RAM.
// One character per cycle; refresh, force, freeze and highlighting.
module vga_hex_writer
    import vga_pkg::*;
#(
    parameter int N_CH       = 16,
    parameter int CH_W       = 32,
    parameter int COLS       = 80,
    parameter int CH_PER_ROW = 2,
    parameter int BASE_ROW   = 0,
    parameter int ADDR_W     = 12,
    parameter int REFRESH    = 1_000_000,
    parameter int HILITE     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*CH_W-1:0]   ch_data,
    input  logic                   freeze,
    input  logic                   force_i,
    output logic                   busy,
    output logic                   display_wen,
    output logic [ADDR_W-1:0]      display_w_addr,
    output logic [7:0]             display_w_data
);

    localparam int NIB = CH_W / 4;
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int SW  = (CH_PER_ROW > 1) ? $clog2(CH_PER_ROW) : 1;
    localparam int RW  = $clog2(REFRESH);

    localparam logic [CW-1:0]     C_LAST = CW'(N_CH - 1);
    localparam logic [NW-1:0]     N_LAST = NW'(NIB - 1);
    localparam logic [SW-1:0]     S_LAST = SW'(CH_PER_ROW - 1);
    localparam logic [RW-1:0]     R_LAST = RW'(REFRESH - 1);
    localparam logic [ADDR_W-1:0] ROW0   = ADDR_W'(BASE_ROW * COLS);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

    wr_state_e             state_q, state_d;
    logic [RW-1:0]         cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [N_CH*CH_W-1:0]  cur_q, cur_d;
    logic [N_CH-1:0]       chg_q, chg_d;
    logic [CW-1:0]         c_q, c_d;
    logic [NW-1:0]         n_q, n_d;
    logic [SW-1:0]         s_q, s_d;
    logic [ADDR_W-1:0]     rs_q, rs_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;

    logic                  wen_q;
    logic [ADDR_W-1:0]     wa_q;
    logic [7:0]            wd_q;

    logic                  tick;
    logic                  trig;
    logic [3:0]            nib;
    logic                  hl;
    logic [7:0]            code;

    assign tick  = (cnt_q == R_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    assign trig  = (tick & ~freeze) | force_i;

    // Sweep sequencing: snapshot on entry, walk (c, n), track address
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        chg_d   = chg_q;
        c_d     = c_q;
        n_d     = n_q;
        s_d     = s_q;
        rs_d    = rs_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (trig | pend_q) begin
                    state_d = WRITE;
                    pend_d  = 1'b0;
                    cur_d   = ch_data;
                    for (int i = 0; i < N_CH; i++) begin
                        chg_d[i] = ch_data[i*CH_W +: CH_W]
                                   != cur_q[i*CH_W +: CH_W];
                    end
                    c_d    = '0;
                    n_d    = '0;
                    s_d    = '0;
                    rs_d   = ROW0;
                    addr_d = ROW0;
                end
            end
            WRITE: begin
                if (trig) begin
                    pend_d = 1'b1;
                end
                if (n_q != N_LAST) begin
                    n_d    = n_q + 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                end else if (c_q == C_LAST) begin
                    state_d = IDLE;
                end else begin
                    n_d = '0;
                    c_d = c_q + 1'b1;
                    if (s_q == S_LAST) begin
                        s_d    = '0;
                        rs_d   = rs_q + COLS_A;
                        addr_d = rs_q + COLS_A;
                    end else begin
                        s_d    = s_q + 1'b1;
                        addr_d = addr_q + ADDR_W'(2);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Select the nibble (MSB first) and change flag for the next write
    always_comb begin
        nib = '0;
        hl  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            for (int j = 0; j < NIB; j++) begin
                if (c_d == CW'(i) && n_d == NW'(j)) begin
                    nib = cur_d[i*CH_W + (NIB-1-j)*4 +: 4];
                    hl  = (HILITE != 0) && chg_d[i];
                end
            end
        end
    end

    vga_hex_char u_char (
        .nib_i  (nib),
        .hl_i   (hl),
        .code_o (code)
    );

    // Sequencer and registered display port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            cur_q   <= '0;
            chg_q   <= '0;
            c_q     <= '0;
            n_q     <= '0;
            s_q     <= '0;
            rs_q    <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            chg_q   <= chg_d;
            c_q     <= c_d;
            n_q     <= n_d;
            s_q     <= s_d;
            rs_q    <= rs_d;
            addr_q  <= addr_d;
            wen_q   <= (state_d == WRITE);
            wa_q    <= (state_d == WRITE) ? addr_d : '0;
            wd_q    <= (state_d == WRITE) ? code : '0;
        end
    end

    assign busy           = wen_q;
    assign display_wen    = wen_q;
    assign display_w_addr = wa_q;
    assign display_w_data = wd_q;

endmodule

// File: tb/tb_vga_hex_writer.sv
// Self-checking bench for vga_hex_writer against a sweep-level model.
// Directed scenarios pin literal values; a random phase runs the model.
module tb_vga_hex_writer;

    localparam int N_CH     = 2;
    localparam int CH_W     = 8;
    localparam int COLS     = 80;
    localparam int CPR      = 1;
    localparam int BASE_ROW = 2;
    localparam int ADDR_W   = 12;
    localparam int REFRESH  = 40;
    localparam int HILITE   = 1;
    localparam int NIB      = CH_W / 4;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N_CH*CH_W-1:0]  ch_data = '0;
    logic                  freeze = 1'b0;
    logic                  force_i = 1'b0;
    logic                  busy;
    logic                  display_wen;
    logic [ADDR_W-1:0]     display_w_addr;
    logic [7:0]            display_w_data;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    wr_t m_q[$];
    wr_t log_q[$];
    int  m_cnt  = 0;
    bit  m_pend = 0;
    logic [N_CH*CH_W-1:0] m_snap = '0;

    vga_hex_writer #(
        .N_CH       (N_CH),
        .CH_W       (CH_W),
        .COLS       (COLS),
        .CH_PER_ROW (CPR),
        .BASE_ROW   (BASE_ROW),
        .ADDR_W     (ADDR_W),
        .REFRESH    (REFRESH),
        .HILITE     (HILITE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_data        (ch_data),
        .freeze         (freeze),
        .force_i        (force_i),
        .busy           (busy),
        .display_wen    (display_wen),
        .display_w_addr (display_w_addr),
        .display_w_data (display_w_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Build the full list of writes for one sweep from the snapshot rules
    task automatic start_sweep();
        logic [N_CH*CH_W-1:0] old;
        old = m_snap;
        m_snap = ch_data;
        m_pend = 0;
        for (int c = 0; c < N_CH; c++) begin
            bit chg;
            chg = (m_snap[c*CH_W +: CH_W] != old[c*CH_W +: CH_W]);
            for (int n = 0; n < NIB; n++) begin
                wr_t w;
                int v;
                v = int'(m_snap[c*CH_W + (NIB-1-n)*4 +: 4]);
                w.data = (v < 10) ? 'h30 + v : 'h41 + v - 10;
                if (HILITE == 1 && chg) w.data = w.data | 'h80;
                w.addr = (BASE_ROW + c / CPR) * COLS
                         + (c % CPR) * (NIB + 1) + n;
                w.cyc = 0;
                m_q.push_back(w);
            end
        end
    endtask

    // Reference model: refresh counter, pending flag, queue of writes
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  = 0;
            m_pend = 0;
            m_snap = '0;
            m_q.delete();
        end else begin
            bit tk, tr;
            tk = (m_cnt == REFRESH - 1);
            m_cnt = tk ? 0 : m_cnt + 1;
            tr = (tk && !freeze) || force_i;
            if (m_q.size() > 0) begin
                if (tr) m_pend = 1;
                void'(m_q.pop_front());
            end else if (tr || m_pend) begin
                start_sweep();
            end
        end
    end

    // Per-cycle comparison of the display port against the model
    always @(negedge clk) begin
        bit ew;
        cyc++;
        ew = (m_q.size() > 0);
        chk("wen", display_wen, ew);
        chk("busy", busy, ew);
        if (ew) begin
            chk("addr", display_w_addr, m_q[0].addr);
            chk("data", display_w_data, m_q[0].data);
        end
        if (display_wen) begin
            wr_t w;
            w.addr = int'(display_w_addr);
            w.data = int'(display_w_data);
            w.cyc  = cyc;
            log_q.push_back(w);
        end
    end

    task automatic pulse_force();
        @(negedge clk);
        force_i = 1'b1;
        @(negedge clk);
        force_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_q.size() == 0 && !m_pend) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_log(input string nm, input int i,
                           input int a, input int d);
        if (log_q.size() > i) begin
            chk({nm, "_addr"}, log_q[i].addr, a);
            chk({nm, "_data"}, log_q[i].data, d);
        end else begin
            chk({nm, "_missing"}, log_q.size(), i + 1);
        end
    endtask

    initial begin
        int first;
        #1 rst = 1'b0;
        #3;
        chk("rst_wen", display_wen, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", display_w_addr, 0);
        chk("rst_data", display_w_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        first = -1;
        for (int i = 1; i <= 2 * REFRESH; i++) begin
            @(negedge clk);
            if (display_wen) begin
                first = i;
                break;
            end
        end
        chk("first_tick_cycle", first, REFRESH);
        wait_idle();
        freeze = 1'b1;

        log_q.delete();
        ch_data = 16'h3CA5;
        pulse_force();
        wait_idle();
        chk("sweep1_len", log_q.size(), 4);
        chk_log("s1w0", 0, 160, 'hC1);
        chk_log("s1w1", 1, 161, 'hB5);
        chk_log("s1w2", 2, 240, 'hB3);
        chk_log("s1w3", 3, 241, 'hC3);
        if (log_q.size() == 4)
            chk("sweep1_consec", log_q[3].cyc - log_q[0].cyc, 3);

        log_q.delete();
        ch_data = 16'h3DA5;
        pulse_force();
        wait_idle();
        chk("sweep2_len", log_q.size(), 4);
        chk_log("s2w0", 0, 160, 'h41);
        chk_log("s2w1", 1, 161, 'h35);
        chk_log("s2w2", 2, 240, 'hB3);
        chk_log("s2w3", 3, 241, 'hC4);

        log_q.delete();
        repeat (2 * REFRESH + 4) @(negedge clk);
        chk("frozen_writes", log_q.size(), 0);

        log_q.delete();
        pulse_force();
        wait_idle();
        chk("force_frozen_len", log_q.size(), 4);

        log_q.delete();
        @(negedge clk);
        force_i = 1'b1;
        repeat (4) @(negedge clk);
        force_i = 1'b0;
        wait_idle();
        chk("collapse_len", log_q.size(), 8);
        if (log_q.size() == 8)
            chk("collapse_gap", log_q[4].cyc - log_q[3].cyc, 2);

        log_q.delete();
        @(negedge clk);
        force_i = 1'b1;
        @(negedge clk);
        force_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_wen", display_wen, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", display_w_addr, 0);
        chk("midrst_data", display_w_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_writes", log_q.size(), 1);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 2) == 0)
                    ch_data[c*CH_W +: CH_W] = CH_W'($urandom);
            end
            force_i = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 31) == 0) freeze = ~freeze;
        end
        @(negedge clk);
        force_i = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
